// File: rtl/mfp_ahb_lite_pkg.sv
// Shared encodings for the AHB-Lite interconnect: transfer types, responses
// and the default-slave state machine.
package mfp_ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // Observation bundle: current FSM state and direction of the last error.
  typedef struct packed {
    ds_state_t state;
    logic      err_write;
  } ds_dbg_t;

endpackage

// File: rtl/mfp_ahb_lite_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for active transfers,
// zero-wait OKAY otherwise, plus a saturating count of unmapped accesses.
module mfp_ahb_lite_default_slave
  import mfp_ahb_lite_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HREADY,
  input  logic                sel,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [ERRCNT_W-1:0] ERR_COUNT,
  output ds_dbg_t             dbg
);

  ds_state_t state, state_next;
  logic      err_write;
  logic      start_err;

  // An address phase is only accepted when the bus-wide HREADY is high.
  assign start_err = HREADY & sel &
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= DS_IDLE;
      ERR_COUNT <= '0;
      err_write <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == DS_ERR1 && ERR_COUNT != '1)
        ERR_COUNT <= ERR_COUNT + ERRCNT_W'(1);
      if (start_err)
        err_write <= HWRITE;
    end
  end

  always_comb begin
    state_next = state;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state)
      DS_IDLE: begin
        if (start_err) state_next = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP      = HRESP_ERROR;
        state_next = start_err ? DS_ERR1 : DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

  assign dbg = '{state: state, err_write: err_write};

endmodule

// File: rtl/mfp_ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: parametrised address decode, data-phase
// owner tracking and zero-latency response mux with an internal default slave.
module mfp_ahb_lite_interconnect
  import mfp_ahb_lite_pkg::*;
#(
  parameter int                      N_SLAVES   = 4,
  parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {N_SLAVES{32'h0}},
  parameter int                      ERRCNT_W   = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  output logic [31:0]            HRDATA,
  output logic                   HREADY,
  output logic                   HRESP,
  output logic [N_SLAVES-1:0]    S_HSEL,
  input  logic [N_SLAVES*32-1:0] S_HRDATA,
  input  logic [N_SLAVES-1:0]    S_HREADYOUT,
  input  logic [N_SLAVES-1:0]    S_HRESP,
  output logic [ERRCNT_W-1:0]    ERR_COUNT,
  output ds_dbg_t                DS_DBG
);

  logic [N_SLAVES-1:0]         hit;
  logic                        def_sel;
  logic [N_SLAVES:0]           dsel;
  logic [N_SLAVES-1:0][31:0]   rd_masked;
  logic                        def_ready;
  logic                        def_resp;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_decode
    localparam logic [N_SLAVES-1:0] BELOW = N_SLAVES'((1 << i) - 1);
    assign hit[i]    = (HADDR & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32];
    // Lowest-index window wins when windows overlap.
    assign S_HSEL[i] = hit[i] & ~|(hit & BELOW);
  end

  assign def_sel = ~|hit;

  // Data-phase owner; all-zero means no transfer has been accepted since reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      dsel <= '0;
    else if (HREADY)
      dsel <= {def_sel, S_HSEL};
  end

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_rdata
    assign rd_masked[i] = {32{dsel[i]}} & S_HRDATA[32*i +: 32];
  end

  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < N_SLAVES; i++)
      HRDATA = HRDATA | rd_masked[i];
  end

  assign HREADY = ~|dsel
                | |(dsel[N_SLAVES-1:0] & S_HREADYOUT)
                | (dsel[N_SLAVES] & def_ready);
  assign HRESP  = |(dsel[N_SLAVES-1:0] & S_HRESP)
                | (dsel[N_SLAVES] & def_resp);

  mfp_ahb_lite_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HREADY    (HREADY),
    .sel       (def_sel),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADYOUT (def_ready),
    .HRESP     (def_resp),
    .ERR_COUNT (ERR_COUNT),
    .dbg       (DS_DBG)
  );

endmodule

// File: tb/tb_mfp_ahb_lite_interconnect.sv
// Bench for mfp_ahb_lite_interconnect: directed bus scenarios then random
// traffic, checked against a transaction-level model of owner and error responses.
module tb_mfp_ahb_lite_interconnect;
  import mfp_ahb_lite_pkg::*;

  localparam int N = 4;
  localparam logic [N*32-1:0] BASE = {32'h0000_0000, 32'h0080_0000, 32'h1000_0000, 32'h1FC0_0000};
  localparam logic [N*32-1:0] MASK = {32'hFFFF_0000, 32'hFF80_0000, 32'h1000_0000, 32'h1FC0_0000};

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  logic HRESETn;

  logic [31:0]    HADDR;
  logic [1:0]     HTRANS;
  logic           HWRITE;
  logic [31:0]    HRDATA;
  logic           HREADY, HRESP;
  logic [N-1:0]   S_HSEL;
  logic [N*32-1:0] S_HRDATA;
  logic [N-1:0]   S_HREADYOUT, S_HRESP;
  logic [15:0]    ERR_COUNT;
  ds_dbg_t        DS_DBG;

  // Narrow-counter instance on the same bus, to reach saturation quickly.
  logic [31:0]    b_hrdata;
  logic           b_hready, b_hresp;
  logic [N-1:0]   b_hsel;
  logic [2:0]     b_err_count;
  ds_dbg_t        b_dbg;

  mfp_ahb_lite_interconnect #(
    .N_SLAVES(N), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .ERRCNT_W(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .S_HSEL(S_HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_COUNT(ERR_COUNT), .DS_DBG(DS_DBG)
  );

  mfp_ahb_lite_interconnect #(
    .N_SLAVES(N), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .ERRCNT_W(3)
  ) dut_w3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(b_hrdata), .HREADY(b_hready), .HRESP(b_hresp), .S_HSEL(b_hsel),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_COUNT(b_err_count), .DS_DBG(b_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;

  // Pending default-slave responses {HREADY,HRESP}; empty means zero-wait OKAY.
  logic [1:0] exp_q[$];
  int         owner;     // -1 none, 0..N-1 slave, N default slave
  int         err_cnt;
  int         exp_idx;
  logic       e_ready, e_resp;
  logic [31:0] e_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
    return N;
  endfunction

  function automatic logic [31:0] sat(input int v, input int lim);
    return (v > lim) ? 32'(lim) : 32'(v);
  endfunction

  task automatic model_outputs();
    if (owner < 0) begin
      e_ready = 1'b1; e_resp = 1'b0; e_rdata = '0;
    end else if (owner < N) begin
      e_ready = S_HREADYOUT[owner]; e_resp = S_HRESP[owner]; e_rdata = S_HRDATA[32*owner +: 32];
    end else begin
      if (exp_q.size() > 0) {e_ready, e_resp} = exp_q[0];
      else                  {e_ready, e_resp} = 2'b10;
      e_rdata = '0;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later.
  task automatic settle();
    logic [31:0] e_hsel;
    #1;
    model_outputs();
    exp_idx = decode(HADDR);
    e_hsel  = (exp_idx < N) ? (32'd1 << exp_idx) : 32'd0;
    check("hsel",      32'(S_HSEL),      e_hsel);
    check("hsel_w3",   32'(b_hsel),      e_hsel);
    check("hready",    32'(HREADY),      32'(e_ready));
    check("hresp",     32'(HRESP),       32'(e_resp));
    check("hrdata",    HRDATA,           e_rdata);
    check("err_count", 32'(ERR_COUNT),   sat(err_cnt, 65535));
    check("err_count_w3", 32'(b_err_count), sat(err_cnt, 7));
  endtask

  task automatic advance();
    @(posedge HCLK);
    if (!HRESETn) begin
      owner = -1; err_cnt = 0; exp_q.delete();
    end else begin
      if (owner == N && exp_q.size() > 0) void'(exp_q.pop_front());
      if (e_ready) begin
        owner = exp_idx;
        if (owner == N && HTRANS[1]) begin
          exp_q.push_back(2'b01);
          exp_q.push_back(2'b11);
          err_cnt++;
        end
      end
    end
    @(negedge HCLK);
  endtask

  // ---------------- driver helpers ----------------
  task automatic master(input logic [31:0] a, input logic [1:0] t);
    HADDR = a; HTRANS = t; HWRITE = 1'b0;
  endtask

  task automatic slaves_quiet();
    for (int i = 0; i < N; i++) begin
      S_HREADYOUT[i] = 1'b1;
      S_HRESP[i]     = 1'b0;
      S_HRDATA[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pool [6];
    pool = '{32'hBFC0_0010, 32'h1000_0004, 32'h0080_0020, 32'h0000_1230, 32'h0040_0000, 32'h0};
    owner = -1; err_cnt = 0;
    HRESETn = 1'b0;
    master(32'h0, HTRANS_IDLE);
    slaves_quiet();
    @(posedge HCLK);
    @(negedge HCLK);
    settle();
    check("rst_hready", 32'(HREADY), 32'd1);
    check("rst_errcnt", 32'(ERR_COUNT), 32'd0);
    advance();
    HRESETn = 1'b1;

    // Read through window 0 (also overlapping window 1).
    master(32'hBFC0_0010, HTRANS_NONSEQ);
    S_HRDATA[31:0] = 32'h1234_5678;
    settle();
    check("t1_hsel", 32'(S_HSEL), 32'h1);
    advance();
    master(32'h0000_1230, HTRANS_IDLE);
    settle();
    check("t1_rdata", HRDATA, 32'h1234_5678);
    check("t1_hresp", 32'(HRESP), 32'd0);
    advance();

    // Slave 1 stretches three cycles; pipelined slave-2 address must wait.
    master(32'h1000_0004, HTRANS_NONSEQ);
    settle(); advance();
    master(32'h0080_0020, HTRANS_NONSEQ);
    S_HRDATA[95:64] = 32'hCAFE_0002;
    for (int k = 0; k < 3; k++) begin
      S_HREADYOUT[1] = 1'b0;
      settle();
      check("t2_stretch", 32'(HREADY), 32'd0);
      advance();
    end
    S_HREADYOUT[1] = 1'b1;
    settle();
    check("t2_release", 32'(HREADY), 32'd1);
    advance();
    master(32'h0000_1230, HTRANS_IDLE);
    settle();
    check("t2_rdata", HRDATA, 32'hCAFE_0002);
    advance();

    // Unmapped NONSEQ: ERROR pair, then OKAY.
    master(32'h0040_0000, HTRANS_NONSEQ);
    settle();
    check("t3_hsel", 32'(S_HSEL), 32'h0);
    advance();
    master(32'h0000_1230, HTRANS_IDLE);
    settle();
    check("t3_err1", 32'({HREADY, HRESP}), 32'b01);
    check("t3_cnt", 32'(ERR_COUNT), 32'd1);
    advance();
    settle();
    check("t3_err2", 32'({HREADY, HRESP}), 32'b11);
    advance();
    settle();
    check("t3_okay", 32'({HREADY, HRESP}), 32'b10);
    advance();

    // Unmapped IDLE: zero-wait OKAY, count unchanged.
    master(32'h0040_0000, HTRANS_IDLE);
    settle(); advance();
    settle();
    check("t4_okay", 32'({HREADY, HRESP}), 32'b10);
    check("t4_cnt", 32'(ERR_COUNT), 32'd1);
    advance();

    // Back-to-back unmapped transfers; narrow counter saturates at 7.
    master(32'h0040_0000, HTRANS_NONSEQ);
    settle(); advance();
    master(32'h0040_0100, HTRANS_SEQ);
    for (int k = 0; k < 12; k++) begin
      settle();
      check("t5_pattern", 32'({HREADY, HRESP}), (k % 2 == 0) ? 32'b01 : 32'b11);
      advance();
    end
    master(32'h0000_1230, HTRANS_IDLE);
    settle();
    check("t5_cnt16", 32'(ERR_COUNT), 32'd8);
    check("t5_cnt3_sat", 32'(b_err_count), 32'd7);
    advance();
    settle(); advance();

    // Reset while the default slave is in its first error cycle.
    master(32'h0040_0000, HTRANS_NONSEQ);
    settle(); advance();
    master(32'h0000_1230, HTRANS_IDLE);
    HRESETn = 1'b0;
    settle();
    check("t6_err1", 32'({HREADY, HRESP}), 32'b01);
    advance();
    HRESETn = 1'b1;
    settle();
    check("t6_after_rst", 32'({HREADY, HRESP}), 32'b10);
    check("t6_cnt", 32'(ERR_COUNT), 32'd0);
    advance();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      HRESETn = ($urandom_range(0, 99) != 0);
      pool[5] = $urandom;
      HADDR   = pool[$urandom_range(0, 5)];
      HTRANS  = 2'($urandom_range(0, 3));
      HWRITE  = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        S_HREADYOUT[i] = ($urandom_range(0, 3) != 0);
        S_HRESP[i]     = ($urandom_range(0, 9) == 0);
        S_HRDATA[32*i +: 32] = $urandom;
      end
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
